// File: rtl/hwpe_ctrl_uloop_driver_pkg.sv
// Shared types for the uloop driver: uloop ctrl/flags records, tile descriptor and driver FSM states.
package hwpe_ctrl_uloop_driver_pkg;

  localparam int unsigned ULOOP_NB_REG    = 4;
  localparam int unsigned ULOOP_NB_LOOPS  = 6;
  localparam int unsigned ULOOP_REG_WIDTH = 32;
  localparam int unsigned ULOOP_CNT_WIDTH = 16;

  typedef struct packed {
    logic enable;
    logic clear;
  } ctrl_uloop_t;

  typedef struct packed {
    logic                                              valid;
    logic                                              ready;
    logic                                              done;
    logic [ULOOP_NB_REG-1:0][ULOOP_REG_WIDTH-1:0]      offs;
    logic [ULOOP_NB_LOOPS-1:0][ULOOP_CNT_WIDTH-1:0]    idx;
  } flags_uloop_t;

  typedef struct packed {
    logic [ULOOP_NB_REG-1:0][ULOOP_REG_WIDTH-1:0]      offs;
    logic [ULOOP_NB_LOOPS-1:0][ULOOP_CNT_WIDTH-1:0]    idx;
    logic                                              last;
  } uloop_desc_t;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    FETCH,
    WAIT,
    HOLD,
    DRAIN
  } uloop_drv_state_t;

  function automatic uloop_desc_t desc_from_flags(flags_uloop_t f);
    uloop_desc_t d;
    d.offs = f.offs;
    d.idx  = f.idx;
    d.last = f.done;
    return d;
  endfunction

endpackage

// File: rtl/hwpe_ctrl_uloop_desc_fifo.sv
// Two-entry descriptor buffer; push and pop may coincide at any occupancy, including full.
module hwpe_ctrl_uloop_desc_fifo
  import hwpe_ctrl_uloop_driver_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        push_i,
  input  uloop_desc_t desc_i,
  input  logic        pop_i,
  output uloop_desc_t desc_o,
  output logic [1:0]  count_o
);

  uloop_desc_t mem_q [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;
  logic        do_push;
  logic        do_pop;

  assign do_pop  = pop_i & (count_q != 2'd0);
  // When full, a push is only legal if the head leaves in the same cycle.
  assign do_push = push_i & ((count_q != 2'd2) | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (clear_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= desc_i;
  end

  assign desc_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/hwpe_ctrl_uloop_driver.sv
// Drives a uloop instance iteration by iteration and forwards each iteration's flags as a tile descriptor.
module hwpe_ctrl_uloop_driver
  import hwpe_ctrl_uloop_driver_pkg::*;
#(
  parameter int unsigned NB_REG     = ULOOP_NB_REG,
  parameter int unsigned NB_LOOPS   = ULOOP_NB_LOOPS,
  parameter int unsigned REG_WIDTH  = ULOOP_REG_WIDTH,
  parameter int unsigned CNT_WIDTH  = ULOOP_CNT_WIDTH,
  parameter int unsigned SHADOWED   = 0,
  parameter int unsigned TCNT_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic                          start_i,
  output logic                          busy_o,
  output logic                          done_o,
  output ctrl_uloop_t                   uloop_ctrl_o,
  input  flags_uloop_t                  uloop_flags_i,
  output logic                          desc_valid_o,
  input  logic                          desc_ready_i,
  output logic [NB_REG*REG_WIDTH-1:0]   desc_offs_o,
  output logic [NB_LOOPS*CNT_WIDTH-1:0] desc_idx_o,
  output logic                          desc_last_o,
  output logic [TCNT_WIDTH-1:0]         tile_cnt_o
);

  uloop_drv_state_t      state_q, state_d;
  logic                  push;
  logic                  pop;
  logic [1:0]            count;
  logic [1:0]            count_after_push;
  uloop_desc_t           head;
  logic                  done_d, done_q;
  logic [TCNT_WIDTH-1:0] tile_cnt_q;

  hwpe_ctrl_uloop_desc_fifo u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (push),
    .desc_i  (desc_from_flags(uloop_flags_i)),
    .pop_i   (pop),
    .desc_o  (head),
    .count_o (count)
  );

  assign desc_valid_o     = (count != 2'd0);
  assign pop              = desc_valid_o & desc_ready_i;
  assign count_after_push = count + 2'd1 - {1'b0, pop};

  always_comb begin
    state_d      = state_q;
    push         = 1'b0;
    done_d       = 1'b0;
    uloop_ctrl_o = '0;
    if (clear_i) begin
      state_d            = IDLE;
      uloop_ctrl_o.clear = (state_q != IDLE);
    end else begin
      unique case (state_q)
        IDLE:  if (start_i) state_d = CLR;
        CLR: begin
          uloop_ctrl_o.clear = 1'b1;
          state_d            = FETCH;
        end
        FETCH, WAIT: begin
          if (uloop_flags_i.valid) begin
            // Capture cycle: keep enable low so the uloop does not run past this iteration.
            push = 1'b1;
            if (uloop_flags_i.done)          state_d = DRAIN;
            else if (count_after_push < 2'd2) state_d = FETCH;
            else                              state_d = HOLD;
          end else if (state_q == FETCH) begin
            if (SHADOWED != 0) begin
              uloop_ctrl_o.enable = uloop_flags_i.ready;
              if (uloop_flags_i.ready) state_d = WAIT;
            end else begin
              uloop_ctrl_o.enable = ~uloop_flags_i.valid;
            end
          end
        end
        HOLD:  if (pop) state_d = FETCH;
        DRAIN: begin
          if (pop && head.last) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      done_q     <= 1'b0;
      tile_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (clear_i || state_q == CLR) tile_cnt_q <= '0;
      else if (pop)                  tile_cnt_q <= tile_cnt_q + TCNT_WIDTH'(1);
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign tile_cnt_o  = tile_cnt_q;
  // Buffer storage is not reset, so the payload is masked while nothing is valid.
  assign desc_offs_o = desc_valid_o ? head.offs : '0;
  assign desc_idx_o  = desc_valid_o ? head.idx  : '0;
  assign desc_last_o = desc_valid_o & head.last;

  a_flags_valid_when_fetching: assert property (@(posedge clk_i) disable iff (!rst_ni)
    uloop_flags_i.valid |-> (clear_i || state_q == FETCH || state_q == WAIT));

endmodule
